// File: rtl/rd_port_arbiter.sv
// Multi-port read scheduler: grants whole-transfer requests, splits them into bursts for the AXI read master.
// Optional build macro RD_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rd_port_arbiter #(
  parameter int         NUM_PORTS  = 2,
  parameter int         ADDR_WIDTH = 27,
  parameter int         DATA_WIDTH = 16,
  parameter logic [7:0] MAX_BURST  = 8'd8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            init_end,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*16-1:0]         req_len,
  output logic [NUM_PORTS-1:0]            req_ack,
  output logic [DATA_WIDTH-1:0]           port_data,
  output logic [NUM_PORTS-1:0]            port_data_en,
  output logic [NUM_PORTS-1:0]            port_done,
  output logic                            rd_trig,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [7:0]                      rd_len,
  input  logic                            rd_ready,
  input  logic                            rd_done,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  input  logic                            rd_data_en
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        grant_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q;
  logic [15:0]             remaining_q;
  logic [NUM_PORTS-1:0]    req_ack_q;
  logic [NUM_PORTS-1:0]    port_done_q;
  logic                    rd_trig_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [7:0]              rd_len_q;
`ifndef RD_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]        last_grant_q;
`endif

  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [15:0]             sel_len;
  logic [7:0]              chunk_d;
  logic [15:0]             remaining_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_d;
  logic [NUM_PORTS-1:0]    grant_onehot;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
`ifdef RD_ARB_FIXED_PRIO_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[IDX_W'(i)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
`else
    // Scan from the farthest offset down so the port nearest after last_grant wins.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      int cand;
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (req[IDX_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
`endif
  end

  assign sel_addr     = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_len      = req_len[int'(pick_idx)*16 +: 16];
  assign chunk_d      = (remaining_q < 16'(MAX_BURST)) ? remaining_q[7:0] : MAX_BURST;
  assign remaining_d  = remaining_q - 16'(chunk_d);
  assign cur_addr_d   = cur_addr_q + ADDR_WIDTH'(chunk_d);
  assign grant_onehot = NUM_PORTS'(1) << grant_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      req_ack_q   <= '0;
      port_done_q <= '0;
      rd_trig_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
`ifndef RD_ARB_FIXED_PRIO_EN
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
`endif
    end else begin
      req_ack_q   <= '0;
      port_done_q <= '0;
      rd_trig_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (init_end && pick_valid) begin
            grant_q     <= pick_idx;
            cur_addr_q  <= sel_addr;
            remaining_q <= sel_len;
            req_ack_q   <= NUM_PORTS'(1) << pick_idx;
            state_q     <= (sel_len == 16'd0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (rd_ready) begin
            rd_trig_q <= 1'b1;
            rd_addr_q <= cur_addr_q;
            rd_len_q  <= chunk_d;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (rd_done) begin
            remaining_q <= remaining_d;
            cur_addr_q  <= cur_addr_d;
            if (remaining_d == 16'd0) begin
              port_done_q <= grant_onehot;
              state_q     <= FINISH;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        FINISH: begin
          // Zero-length transfers arrive here without a done pulse; emit it now, one cycle after the ack.
          if (port_done_q == '0) port_done_q <= grant_onehot;
`ifndef RD_ARB_FIXED_PRIO_EN
          last_grant_q <= grant_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack      = req_ack_q;
  assign port_done    = port_done_q;
  assign rd_trig      = rd_trig_q;
  assign rd_addr      = rd_addr_q;
  assign rd_len       = rd_len_q;
  assign port_data    = rd_data;
  assign port_data_en = (state_q == WAIT && rd_data_en) ? grant_onehot : '0;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Directed bench for rd_port_arbiter with a simple read-master responder.
module tb_rd_port_arbiter;
  localparam int NP = 2;
  localparam int AW = 27;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn = 1'b0;
  logic              init_end = 1'b0;
  logic [NP-1:0]     req = '0;
  logic [NP*AW-1:0]  req_addr = '0;
  logic [NP*16-1:0]  req_len = '0;
  logic              rd_ready = 1'b1;
  logic              rd_done = 1'b0;
  logic              rd_data_en = 1'b0;
  logic [DW-1:0]     rd_data = 16'h5A00;

  logic [NP-1:0]     req_ack, port_data_en, port_done;
  logic [DW-1:0]     port_data;
  logic              rd_trig;
  logic [AW-1:0]     rd_addr;
  logic [7:0]        rd_len;

  rd_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(8'd8)) dut (
    .clk(clk), .rstn(rstn), .init_end(init_end), .req(req), .req_addr(req_addr),
    .req_len(req_len), .req_ack(req_ack), .port_data(port_data), .port_data_en(port_data_en),
    .port_done(port_done), .rd_trig(rd_trig), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ready(rd_ready), .rd_done(rd_done), .rd_data(rd_data), .rd_data_en(rd_data_en)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Read master responder: len data beats, then a done pulse, then ready again.
  int m_left = 0;
  bit m_active = 0, m_done_sent = 0;
  always begin
    @(posedge clk); #1;
    rd_done    = 1'b0;
    rd_data_en = 1'b0;
    if (!rstn) begin
      rd_ready = 1'b1; m_active = 0; m_left = 0;
    end else if (m_active) begin
      if (m_left > 0) begin
        rd_data_en = 1'b1; rd_data = rd_data + 16'd1; m_left--;
      end else if (!m_done_sent) begin
        rd_done = 1'b1; m_done_sent = 1;
      end else begin
        rd_ready = 1'b1; m_active = 0;
      end
    end else if (rd_trig) begin
      rd_ready = 1'b0; m_active = 1; m_left = int'(rd_len); m_done_sent = 0;
    end
  end

  // Monitor
  int cyc = 0, trig_cnt = 0, data_err = 0, onehot_err = 0;
  int ack_cyc = 0, done_cyc = 0, rddone_cyc = 0, first_trig_cyc = 0;
  int beats[NP];
  int done_cnt[NP];
  logic [AW-1:0] b_addr[$];
  logic [7:0]    b_len[$];
  always @(negedge clk) begin
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (port_data_en[p]) beats[p]++;
      if (port_done[p]) done_cnt[p]++;
    end
    if (port_data !== rd_data) data_err++;
    if ($countones(req_ack) > 1 || $countones(port_data_en) > 1 || $countones(port_done) > 1) onehot_err++;
    if (req_ack != '0) ack_cyc = cyc;
    if (port_done != '0) done_cyc = cyc;
    if (rd_done) rddone_cyc = cyc;
    if (rd_trig) begin
      if (trig_cnt == 0) first_trig_cyc = cyc;
      trig_cnt++; b_addr.push_back(rd_addr); b_len.push_back(rd_len);
    end
  end

  task automatic clear_mon();
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin beats[p] = 0; done_cnt[p] = 0; end
    trig_cnt = 0; data_err = 0; onehot_err = 0;
    b_addr.delete(); b_len.delete();
  endtask

  task automatic run_transfer(input int p, input logic [AW-1:0] a, input logic [15:0] l, output bit ok);
    int i;
    ok = 1;
    @(negedge clk);
    req_addr[p*AW +: AW] = a; req_len[p*16 +: 16] = l; req[p] = 1'b1;
    i = 0;
    while (!req_ack[p] && i < 200) begin @(negedge clk); i++; end
    if (!req_ack[p]) ok = 0;
    req[p] = 1'b0;
    i = 0;
    while (!port_done[p] && i < 2000) begin @(negedge clk); i++; end
    if (!port_done[p]) ok = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ack !== '0) begin n_fail++; $display("FAIL reset_req_ack: got %b want 0", req_ack); end
    n_checks++; if (port_done !== '0) begin n_fail++; $display("FAIL reset_port_done: got %b want 0", port_done); end
    n_checks++; if (port_data_en !== '0) begin n_fail++; $display("FAIL reset_data_en: got %b want 0", port_data_en); end
    n_checks++; if (rd_trig !== 1'b0) begin n_fail++; $display("FAIL reset_rd_trig: got %b want 0", rd_trig); end
    n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    n_checks++; if (rd_len !== 8'd0) begin n_fail++; $display("FAIL reset_rd_len: got %0d want 0", rd_len); end
    n_checks++; if (port_data !== rd_data) begin n_fail++; $display("FAIL reset_port_data: got %h want %h", port_data, rd_data); end
    rstn = 1'b1; init_end = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_burst();
    bit ok;
    clear_mon();
    run_transfer(0, 27'h100, 16'd8, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t1_timeout: got %b want 1", ok); end
    n_checks++; if (trig_cnt !== 1) begin n_fail++; $display("FAIL t1_trig_cnt: got %0d want 1", trig_cnt); end
    n_checks++; if (b_addr[0] !== 27'h100) begin n_fail++; $display("FAIL t1_addr: got %h want 100", b_addr[0]); end
    n_checks++; if (b_len[0] !== 8'd8) begin n_fail++; $display("FAIL t1_len: got %0d want 8", b_len[0]); end
    n_checks++; if (beats[0] !== 8) begin n_fail++; $display("FAIL t1_beats0: got %0d want 8", beats[0]); end
    n_checks++; if (beats[1] !== 0) begin n_fail++; $display("FAIL t1_beats1: got %0d want 0", beats[1]); end
    n_checks++; if (done_cnt[0] !== 1) begin n_fail++; $display("FAIL t1_done0: got %0d want 1", done_cnt[0]); end
    n_checks++; if (first_trig_cyc - ack_cyc !== 1) begin n_fail++; $display("FAIL t1_ack_to_trig: got %0d want 1", first_trig_cyc - ack_cyc); end
    n_checks++; if (data_err !== 0) begin n_fail++; $display("FAIL t1_data_pass: got %0d want 0", data_err); end
  endtask

  task automatic test_multi_burst();
    bit ok;
    logic [AW-1:0] ea[3];
    logic [7:0]    el[3];
    ea = '{27'h200, 27'h208, 27'h210};
    el = '{8'd8, 8'd8, 8'd4};
    clear_mon();
    run_transfer(1, 27'h200, 16'd20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t2_timeout: got %b want 1", ok); end
    n_checks++; if (trig_cnt !== 3) begin n_fail++; $display("FAIL t2_trig_cnt: got %0d want 3", trig_cnt); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (b_addr[k] !== ea[k]) begin n_fail++; $display("FAIL t2_addr%0d: got %h want %h", k, b_addr[k], ea[k]); end
      n_checks++; if (b_len[k] !== el[k]) begin n_fail++; $display("FAIL t2_len%0d: got %0d want %0d", k, b_len[k], el[k]); end
    end
    n_checks++; if (beats[1] !== 20) begin n_fail++; $display("FAIL t2_beats1: got %0d want 20", beats[1]); end
    n_checks++; if (beats[0] !== 0) begin n_fail++; $display("FAIL t2_beats0: got %0d want 0", beats[0]); end
    n_checks++; if (done_cnt[1] !== 1) begin n_fail++; $display("FAIL t2_done1: got %0d want 1", done_cnt[1]); end
    n_checks++; if (done_cnt[0] !== 0) begin n_fail++; $display("FAIL t2_done0: got %0d want 0", done_cnt[0]); end
    n_checks++; if (done_cyc - rddone_cyc !== 1) begin n_fail++; $display("FAIL t2_done_latency: got %0d want 1", done_cyc - rddone_cyc); end
  endtask

  task automatic test_back_to_back();
    int grants[4];
    int exp_g[4];
    int n, i, last;
`ifdef RD_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    clear_mon();
    req_addr = {27'h600, 27'h500};
    req_len  = {16'd4, 16'd4};
    req = 2'b11;
    n = 0; i = 0;
    while (n < 4 && i < 400) begin
      @(negedge clk); i++;
      if (req_ack != '0) begin grants[n] = req_ack[1] ? 1 : 0; n++; end
    end
    req = '0;
    last = (n > 0) ? grants[n-1] : 0;
    i = 0;
    while (!port_done[last] && i < 400) begin @(negedge clk); i++; end
    repeat (2) @(negedge clk);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL t3_ack_count: got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (grants[k] !== exp_g[k]) begin n_fail++; $display("FAIL t3_grant%0d: got %0d want %0d", k, grants[k], exp_g[k]); end
    end
    n_checks++; if (beats[0] + beats[1] !== 16) begin n_fail++; $display("FAIL t3_beats: got %0d want 16", beats[0] + beats[1]); end
    n_checks++; if (onehot_err !== 0) begin n_fail++; $display("FAIL t3_onehot: got %0d want 0", onehot_err); end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_mon();
    run_transfer(0, 27'h700, 16'd0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t4_timeout: got %b want 1", ok); end
    n_checks++; if (done_cyc - ack_cyc !== 1) begin n_fail++; $display("FAIL t4_ack_to_done: got %0d want 1", done_cyc - ack_cyc); end
    n_checks++; if (trig_cnt !== 0) begin n_fail++; $display("FAIL t4_trig_cnt: got %0d want 0", trig_cnt); end
    n_checks++; if (done_cnt[0] !== 1) begin n_fail++; $display("FAIL t4_done0: got %0d want 1", done_cnt[0]); end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    clear_mon();
    run_transfer(1, 27'h7FFFFF8, 16'd12, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t5_timeout: got %b want 1", ok); end
    n_checks++; if (trig_cnt !== 2) begin n_fail++; $display("FAIL t5_trig_cnt: got %0d want 2", trig_cnt); end
    n_checks++; if (b_addr[0] !== 27'h7FFFFF8) begin n_fail++; $display("FAIL t5_addr0: got %h want 7fffff8", b_addr[0]); end
    n_checks++; if (b_len[0] !== 8'd8) begin n_fail++; $display("FAIL t5_len0: got %0d want 8", b_len[0]); end
    n_checks++; if (b_addr[1] !== 27'h0) begin n_fail++; $display("FAIL t5_addr1_wrap: got %h want 0", b_addr[1]); end
    n_checks++; if (b_len[1] !== 8'd4) begin n_fail++; $display("FAIL t5_len1: got %0d want 4", b_len[1]); end
    n_checks++; if (beats[1] !== 12) begin n_fail++; $display("FAIL t5_beats1: got %0d want 12", beats[1]); end
  endtask

  task automatic test_reset_mid_and_init();
    int i, seen, acks;
    bit ok1, ok2, ok3;
    clear_mon();
    @(negedge clk);
    req_addr[0 +: AW] = 27'h300; req_len[0 +: 16] = 16'd20; req[0] = 1'b1;
    i = 0; while (!req_ack[0] && i < 200) begin @(negedge clk); i++; end
    req[0] = 1'b0;
    seen = 0; i = 0;
    while (seen < 2 && i < 400) begin @(negedge clk); i++; if (rd_trig) seen++; end
    ok1 = (seen == 2);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_checks++; if (ok1 !== 1'b1) begin n_fail++; $display("FAIL t6_reach_burst2: got %b want 1", ok1); end
    n_checks++; if (req_ack !== '0 || port_done !== '0) begin n_fail++; $display("FAIL t6_rst_ack_done: got %b/%b want 0/0", req_ack, port_done); end
    n_checks++; if (port_data_en !== '0) begin n_fail++; $display("FAIL t6_rst_data_en: got %b want 0", port_data_en); end
    n_checks++; if (rd_trig !== 1'b0 || rd_addr !== '0 || rd_len !== 8'd0) begin n_fail++; $display("FAIL t6_rst_rd_if: got %b/%h/%0d want 0/0/0", rd_trig, rd_addr, rd_len); end
    n_checks++; if (done_cnt[0] !== 0) begin n_fail++; $display("FAIL t6_no_done: got %0d want 0", done_cnt[0]); end
    @(negedge clk);
    rstn = 1'b1; init_end = 1'b0;
    clear_mon();
    req_addr = {27'h400, 27'h0};
    req_len  = {16'd12, 16'd0};
    req = 2'b11;
    acks = 0;
    repeat (8) begin @(negedge clk); if (req_ack != '0) acks++; end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL t6_init_block: got %0d acks want 0", acks); end
    init_end = 1'b1;
    i = 0; while (req_ack == '0 && i < 50) begin @(negedge clk); i++; end
    n_checks++; if (req_ack !== 2'b01) begin n_fail++; $display("FAIL t6_first_after_reset: got %b want 01", req_ack); end
    req[0] = 1'b0;
    i = 0; while (!req_ack[1] && i < 50) begin @(negedge clk); i++; end
    ok2 = req_ack[1];
    req[1] = 1'b0;
    i = 0; while (!port_done[1] && i < 400) begin @(negedge clk); i++; end
    ok3 = port_done[1];
    repeat (2) @(negedge clk);
    n_checks++; if ({ok2, ok3} !== 2'b11) begin n_fail++; $display("FAIL t6_port1_served: got %b want 11", {ok2, ok3}); end
    n_checks++; if (trig_cnt !== 2) begin n_fail++; $display("FAIL t6_trig_cnt: got %0d want 2", trig_cnt); end
    n_checks++; if (b_addr[0] !== 27'h400 || b_len[0] !== 8'd8) begin n_fail++; $display("FAIL t6_burst0: got %h/%0d want 400/8", b_addr[0], b_len[0]); end
    n_checks++; if (b_addr[1] !== 27'h408 || b_len[1] !== 8'd4) begin n_fail++; $display("FAIL t6_burst1: got %h/%0d want 408/4", b_addr[1], b_len[1]); end
    n_checks++; if (beats[1] !== 12 || beats[0] !== 0) begin n_fail++; $display("FAIL t6_beats: got %0d/%0d want 12/0", beats[1], beats[0]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_back_to_back();
    test_zero_len();
    test_addr_wrap();
    test_reset_mid_and_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rd_port_arbiter.md
# rd_port_arbiter

Multi-port read scheduler between client blocks and the single AXI read master.

- Accepts whole-transfer read requests from `NUM_PORTS` requesters.
- Grants requesters round-robin.
- Splits each transfer into downstream bursts of at most `MAX_BURST` words.
- Drives the read master's `rd_trig`/`rd_addr`/`rd_len` interface.
- Routes returned read data to the granted port only.

## Interface

Parameters:
- `NUM_PORTS`, 2: number of requesters (2..8)
- `ADDR_WIDTH`, 27: word address width
- `DATA_WIDTH`, 16: read data width
- `MAX_BURST`, 8'd8: maximum words per downstream burst (1..255)

Ports (reset `rstn`, synchronous, active-low; clock `clk`):
- `clk` in 1: clock
- `rstn` in 1: synchronous active-low reset
- `init_end` in 1: DDR init complete; no grants while low
- `req` in NUM_PORTS: per-port request level, held until `req_ack`
- `req_addr` in NUM_PORTS*ADDR_WIDTH: start word address; port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_len` in NUM_PORTS*16: total words; port i at slice [i*16 +: 16]
- `req_ack` out NUM_PORTS: one-cycle accept pulse, one-hot
- `port_data` out DATA_WIDTH: shared read data
- `port_data_en` out NUM_PORTS: one-hot data valid for the granted port
- `port_done` out NUM_PORTS: one-cycle transfer-complete pulse
- `rd_trig` out 1: one-cycle burst start pulse to the read master
- `rd_addr` out ADDR_WIDTH: burst start address
- `rd_len` out 8: burst word count
- `rd_ready` in 1: read master idle
- `rd_done` in 1: read master burst complete pulse
- `rd_data` in DATA_WIDTH: read data
- `rd_data_en` in 1: read data valid

## Operation

States: IDLE, ISSUE, WAIT, FINISH.

- **IDLE**
  - When `init_end`=1 and any `req` bit is high, pick the first requesting port at or after `last_grant+1` (modulo `NUM_PORTS`).
  - At the same edge: register `grant`, latch `cur_addr`/`remaining` from that port's slices, and pulse `req_ack[grant]`.
  - If the latched length is nonzero, go to ISSUE. If it is 0, go to FINISH with no downstream activity.
- **ISSUE**
  - Wait for `rd_ready`=1.
  - Then register `rd_trig`=1 for one cycle with `rd_addr`=`cur_addr` and `rd_len`=`chunk`, where `chunk` = min(`remaining`, `MAX_BURST`).
  - Go to WAIT.
- **WAIT**
  - `port_data` = `rd_data` (combinational pass-through).
  - `port_data_en` = `rd_data_en` ? (1<<`grant`) : 0 (combinational).
  - On `rd_done`:
    - `remaining` -= `chunk`.
    - `cur_addr` += `chunk`; the sum wraps modulo 2^ADDR_WIDTH.
    - If `remaining` is now 0, go to FINISH; otherwise go to ISSUE.
- **FINISH**
  - Pulse `port_done[grant]` for one cycle.
  - `last_grant` <= `grant`.
  - Go to IDLE.

Boundary rules:
- `rd_done` is honoured only in WAIT; it is ignored in every other state.
- `rd_data_en` outside WAIT: `port_data_en` = 0.
- `req` is sampled only in IDLE. A `req` that drops before its ack is simply not granted.
- `init_end` falling mid-transfer does not abort the transfer; it only blocks the next grant.
- Reset mid-transfer: immediate return to IDLE; all outputs 0; `last_grant` = `NUM_PORTS`-1, so port 0 wins first. The read master shares `rstn`.
- `remaining` is 16 bits, so the maximum transfer is 65535 words.

## Timing

- Reset values: `req_ack`, `port_done`, `port_data_en` = 0; `rd_trig` = 0; `rd_addr` = 0; `rd_len` = 0. `port_data` follows `rd_data`.
- Request to ack: `req` high at edge N (IDLE) gives `req_ack` high in cycle N+1.
- Ack to trigger: `rd_trig` high in cycle N+2 if `rd_ready` was high in cycle N+1.
- Between bursts: `rd_done` to the next `rd_trig` is at least 2 cycles; ISSUE waits for `rd_ready`, which returns the cycle after `rd_done`.
- `port_done` is high the cycle after the final `rd_done`.
- Earliest next grant is 2 cycles after the final `rd_done`.

## Configuration

- `RD_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest-index requesting port always wins and `last_grant` is unused.
  - Undefined (default): round-robin as described.

## Test plan

1. Port0 `req_len`=8, `addr`=0x100 -> one `rd_trig` with `rd_addr`=0x100, `rd_len`=8; 8 `port_data_en[0]` beats; `port_done[0]` once.
2. Port1 `req_len`=20, `addr`=0x200 -> three bursts: (0x200,8), (0x208,8), (0x210,4); 20 beats on port 1 only; exactly one `port_done[1]`.
3. Both ports request continuously, `len`=4 -> grants alternate 0,1,0,1. With `RD_ARB_FIXED_PRIO_EN` defined -> grants are 0,0,0.
4. `req_len`=0 -> `req_ack` then `port_done` on consecutive cycles; `rd_trig` never asserted.
5. `addr`=2^27-4, `len`=8 with `MAX_BURST`=4 -> second burst `rd_addr`=0.
6. `rstn` low during WAIT of burst 2 -> all outputs 0 next cycle; after release, a new port1 request is served normally. `init_end`=0 -> no ack despite `req`.
